instr_fetch: RTL and testbench

Instruction fetch stage that sits directly upstream of the control decoder. It owns the PC, issues single-outstanding word reads to instruction memory, and buffers one fetched instruction in the IR register that drives the decoder's IR input. Branch and jump resolution downstream redirects it through a one-cycle redirect pulse. Any wrong-path fetch is squashed.

---
 rtl/instr_fetch.sv | 105 ++++++++++
 tb/tb_instr_fetch.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read at a time,
// and holds the fetched word in IR until the decoder consumes it or a redirect flushes it.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    output logic [31:0] IR,
    output logic [31:0] ir_pc,
    input  logic        ir_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {FETCH, WAIT, FULL, DROP} state_t;

    state_t      state, state_n;
    logic [31:0] pc;
    logic [31:0] ir_q;
    logic [31:0] ir_pc_q;
    logic [31:0] count_q;
    logic [31:0] redirect_target;
    logic        capture;
    logic        consume;

    assign redirect_target = redirect_pc & ~32'h3;

    always_comb begin
        state_n = state;
        capture = 1'b0;
        consume = 1'b0;
        case (state)
            FETCH: begin
                if (redirect_valid)
                    state_n = imem_gnt ? DROP : FETCH;
                else if (imem_gnt)
                    state_n = WAIT;
            end
            WAIT: begin
                if (redirect_valid)
                    state_n = imem_rvalid ? FETCH : DROP;
                else if (imem_rvalid) begin
                    state_n = FULL;
                    capture = 1'b1;
                end
            end
            FULL: begin
                if (redirect_valid || ir_ready)
                    state_n = FETCH;
                consume = ir_ready && !redirect_valid;
            end
            // A redirect here only retargets the PC; the squashed response still
            // has to drain, and once it does there is nothing left outstanding.
            DROP: begin
                if (imem_rvalid)
                    state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= FETCH;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            ir_q    <= 32'h0;
            ir_pc_q <= 32'h0;
            count_q <= 32'h0;
        end else begin
            if (redirect_valid)
                pc <= redirect_target;
            else if (capture)
                pc <= pc + PC_STEP;
            if (capture) begin
                ir_q    <= imem_rdata;
                ir_pc_q <= pc;
            end
            if (consume)
                count_q <= count_q + 32'd1;
        end
    end

    // Request is gated by reset so nothing is issued while reset is held.
    assign imem_req    = (state == FETCH) && !rst;
    assign imem_addr   = pc;
    assign ir_valid    = (state == FULL);
    assign IR          = ir_q;
    assign ir_pc       = ir_pc_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by a randomized run checked
// against a program-order model of which address should be fetched/delivered next.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic [31:0] IR;
    logic [31:0] ir_pc;
    logic        ir_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir_valid(ir_valid), .IR(IR), .ir_pc(ir_pc), .ir_ready(ir_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_count(fetch_count)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic idle();
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
        ir_ready = 0; redirect_valid = 0; redirect_pc = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1;
        repeat (3) tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", imem_req); end
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got %0b exp 0", ir_valid); end
        checks++; if (IR !== 32'h0) begin errors++; $display("FAIL reset_IR got %h exp 0", IR); end
        checks++; if (ir_pc !== 32'h0) begin errors++; $display("FAIL reset_ir_pc got %h exp 0", ir_pc); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
        rst = 0; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL reset_first_req got req=%0b addr=%h exp 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_basic();
        idle(); imem_gnt = 1; tick();
        idle(); imem_rvalid = 1; imem_rdata = 32'h2008_0005;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL basic_wait_req got %0b exp 0", imem_req); end
        tick();
        idle(); ir_ready = 1;
        checks++; if (ir_valid !== 1'b1 || IR !== 32'h2008_0005 || ir_pc !== 32'h0) begin errors++; $display("FAIL basic_capture got v=%0b IR=%h pc=%h exp 1/20080005/0", ir_valid, IR, ir_pc); end
        tick();
        idle();
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_1cycle got %0b exp 0", ir_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL basic_next_addr got req=%0b addr=%h exp 1/4", imem_req, imem_addr); end
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", fetch_count); end
    endtask

    task automatic test_stall();
        idle(); imem_gnt = 1; tick();
        idle(); imem_rvalid = 1; imem_rdata = 32'h0041_0113; tick();
        for (int i = 0; i < 5; i++) begin
            idle();
            checks++; if (ir_valid !== 1'b1 || IR !== 32'h0041_0113 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold cyc %0d got v=%0b IR=%h req=%0b exp 1/00410113/0", i, ir_valid, IR, imem_req); end
            tick();
        end
        idle(); ir_ready = 1; tick();
        idle();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_next_addr got req=%0b addr=%h exp 1/8", imem_req, imem_addr); end
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL stall_count got %0d exp 2", fetch_count); end
    endtask

    task automatic test_redirect_full();
        idle(); imem_gnt = 1; tick();
        idle(); imem_rvalid = 1; imem_rdata = 32'h1111_2222; tick();
        idle(); ir_ready = 1; redirect_valid = 1; redirect_pc = 32'h0000_0103; tick();
        idle();
        checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL rfull_flush got %0b exp 0", ir_valid); end
        checks++; if (fetch_count !== 32'd2) begin errors++; $display("FAIL rfull_count got %0d exp 2", fetch_count); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rfull_addr got req=%0b addr=%h exp 1/100", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        idle(); imem_gnt = 1; tick();
        idle(); redirect_valid = 1; redirect_pc = 32'h0000_0200; tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            if (i == 2) begin imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; end
            checks++; if (imem_req !== 1'b0 || ir_valid !== 1'b0) begin errors++; $display("FAIL rwait_drop cyc %0d got req=%0b v=%0b exp 0/0", i, imem_req, ir_valid); end
            tick();
        end
        idle();
        checks++; if (ir_valid !== 1'b0 || IR !== 32'h1111_2222) begin errors++; $display("FAIL rwait_discard got v=%0b IR=%h exp 0/11112222", ir_valid, IR); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rwait_addr got req=%0b addr=%h exp 1/200", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_gnt();
        idle(); imem_gnt = 1; redirect_valid = 1; redirect_pc = 32'h0000_0300; tick();
        idle(); imem_rvalid = 1; imem_rdata = 32'hBAD0_0BAD;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rgnt_drop_req got %0b exp 0", imem_req); end
        tick();
        idle();
        checks++; if (ir_valid !== 1'b0 || IR !== 32'h1111_2222) begin errors++; $display("FAIL rgnt_discard got v=%0b IR=%h exp 0/11112222", ir_valid, IR); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL rgnt_addr got req=%0b addr=%h exp 1/300", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        idle(); redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; tick();
        idle(); imem_gnt = 1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got req=%0b addr=%h exp 1/fffffffc", imem_req, imem_addr); end
        tick();
        idle(); imem_rvalid = 1; imem_rdata = 32'h0000_0013; tick();
        idle(); ir_ready = 1;
        checks++; if (ir_valid !== 1'b1 || ir_pc !== 32'hFFFF_FFFC || IR !== 32'h0000_0013) begin errors++; $display("FAIL wrap_capture got v=%0b pc=%h IR=%h exp 1/fffffffc/00000013", ir_valid, ir_pc, IR); end
        tick();
        idle();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got req=%0b addr=%h exp 1/0", imem_req, imem_addr); end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL wrap_count got %0d exp 3", fetch_count); end
    endtask

    task automatic test_reset_mid();
        idle(); imem_gnt = 1; tick();
        idle(); rst = 1; tick();
        idle();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmid_req_in_reset got %0b exp 0", imem_req); end
        rst = 0; imem_rvalid = 1; imem_rdata = 32'hCAFE_F00D; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr got req=%0b addr=%h exp 1/0", imem_req, imem_addr); end
        tick();
        idle();
        checks++; if (ir_valid !== 1'b0 || IR !== 32'h0 || ir_pc !== 32'h0) begin errors++; $display("FAIL rmid_stray got v=%0b IR=%h pc=%h exp 0/0/0", ir_valid, IR, ir_pc); end
        checks++; if (fetch_count !== 32'd0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_state got cnt=%0d req=%0b addr=%h exp 0/1/0", fetch_count, imem_req, imem_addr); end
    endtask

    // Model: next_pc is the address the next delivered instruction must come from;
    // the memory is a single-slot responder with random grant and latency.
    task automatic test_random();
        logic [31:0] next_pc = 32'h0;
        int          delivered = 0;
        bit          pend = 0;
        int          lat = 0;
        logic [31:0] paddr = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle();
            if (pend) begin
                if (lat == 0) begin imem_rvalid = 1; imem_rdata = mem_word(paddr); pend = 0; end
                else lat--;
            end
            if (imem_req) begin
                checks++; if (pend || imem_rvalid) begin errors++; $display("FAIL rnd_outstanding cyc %0d got req while busy exp none", cyc); end
                checks++; if (imem_addr !== next_pc) begin errors++; $display("FAIL rnd_req_addr cyc %0d got %h exp %h", cyc, imem_addr, next_pc); end
                if ($urandom % 100 < 60) begin
                    imem_gnt = 1; pend = 1; paddr = imem_addr; lat = $urandom_range(0, 2);
                end
            end
            redirect_valid = ($urandom % 100) < 7;
            redirect_pc = ($urandom % 4 == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : $urandom;
            ir_ready = ($urandom % 3) != 0;
            if (ir_valid) begin
                checks++; if (ir_pc !== next_pc || IR !== mem_word(next_pc)) begin errors++; $display("FAIL rnd_deliver cyc %0d got pc=%h IR=%h exp %h/%h", cyc, ir_pc, IR, next_pc, mem_word(next_pc)); end
            end
            checks++; if (fetch_count !== 32'(delivered)) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", cyc, fetch_count, delivered); end
            if (redirect_valid) next_pc = redirect_pc & ~32'h3;
            else if (ir_valid && ir_ready) begin next_pc = next_pc + 32'd4; delivered++; end
            tick();
        end
        checks++; if (delivered < 50) begin errors++; $display("FAIL rnd_progress got %0d exp >=50", delivered); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_basic();
        test_stall();
        test_redirect_full();
        test_redirect_wait();
        test_redirect_gnt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
